// File: rtl/rf_wb_scheduler_pkg.sv
// Shared widths and the buffered long-unit writeback payload.
package rf_wb_scheduler_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering long-unit results until the write port is free.
module rf_wb_fifo
  import rf_wb_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the register-file write port between the Wr stage and buffered
// long-unit results, and stalls ID on hazards against pending long writes.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int unsigned LU_FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_ra,
  input  logic [REG_ADDR_W-1:0] id_rb,
  input  logic [REG_ADDR_W-1:0] id_rw,
  input  logic                  id_wen,
  input  logic                  id_long,
  output logic                  id_stall,
  input  logic                  wb_wen,
  input  logic [REG_ADDR_W-1:0] wb_rw,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rw,
  input  logic [DATA_W-1:0]     lu_data,
  output logic                  lu_ready,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0]     rf_busw
);

  localparam int unsigned CNT_W = $clog2(LU_FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic [STV_W-1:0]    starve_q, starve_d;

  logic [CNT_W-1:0] fifo_count;
  wb_entry_t        fifo_head;
  wb_entry_t        push_entry;
  logic             fifo_empty;
  logic             push, pop, iss;

  assign fifo_empty = (fifo_count == '0);
  assign push_entry = '{rw: lu_rw, data: lu_data};

  rf_wb_fifo #(.DEPTH(LU_FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // Write-port arbitration, hazard detection and scoreboard next state.
  always_comb begin
    id_stall      = 1'b1;
    lu_ready      = 1'b0;
    rf_wen        = 1'b0;
    rf_rw         = '0;
    rf_busw       = '0;
    push          = 1'b0;
    pop           = 1'b0;
    iss           = 1'b0;
    busy_d        = busy_q;
    outstanding_d = outstanding_q;
    starve_d      = starve_q;
    if (rst) begin
      lu_ready = (fifo_count < CNT_W'(LU_FIFO_DEPTH));
      push     = lu_valid & lu_ready;
      if (wb_wen) begin
        rf_wen  = 1'b1;
        rf_rw   = wb_rw;
        rf_busw = wb_data;
      end else if (!fifo_empty) begin
        pop     = 1'b1;
        rf_rw   = fifo_head.rw;
        rf_busw = fifo_head.data;
        rf_wen  = (fifo_head.rw != '0);
      end
      // Registered busy only: a same-cycle writeback does not release the stall.
      id_stall = id_valid & (((id_ra != '0) & busy_q[id_ra]) |
                             ((id_rb != '0) & busy_q[id_rb]) |
                             (id_wen & (id_rw != '0) & busy_q[id_rw]) |
                             (id_long & (outstanding_q == OUT_W'(MAX_OUTSTANDING))) |
                             (starve_q == STV_W'(STARVE_LIMIT)));
      iss = id_valid & id_long & id_wen & ~id_stall;
      if (pop) begin
        busy_d[fifo_head.rw] = 1'b0;
        outstanding_d        = outstanding_d - OUT_W'(1);
      end
      if (iss) begin
        if (id_rw != '0) begin
          busy_d[id_rw] = 1'b1;
        end
        outstanding_d = outstanding_d + OUT_W'(1);
      end
      if (fifo_empty || pop) begin
        starve_d = '0;
      end else if (wb_wen && (starve_q != STV_W'(STARVE_LIMIT))) begin
        starve_d = starve_q + STV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      starve_q      <= '0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      starve_q      <= starve_d;
    end
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Schedules the single register-file write port between two sources: the in-order pipeline Wr stage and a long-latency unit (mul/div) that completes out of band.
- Keeps a 32-bit scoreboard of registers with pending long-unit writes and stalls the ID stage on RAW/WAW hazards against them.
- Sits between the Wr stage, the long unit and the register file's wEn/Rw/busW inputs.
- The register file writes on negedge, so write-port outputs are combinational within the cycle.

Parameters:
- LU_FIFO_DEPTH, 2: entries in the long-unit result buffer (power of 2, ≥2).
- STARVE_LIMIT, 4: cycles a buffered long result may wait before ID is stalled to force a bubble.
- MAX_OUTSTANDING, 4: maximum long ops issued but not yet written back.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset. Clock is clk; sync active-low reset rst.
- id_valid  in  1  valid instruction in ID.
- id_ra  in  5  source register A.
- id_rb  in  5  source register B.
- id_rw  in  5  destination register.
- id_wen  in  1  instruction writes id_rw.
- id_long  in  1  instruction writes back via the long unit.
- id_stall  out  1  hold ID/IF and inject a bubble into EX.
- wb_wen  in  1  Wr stage write request; never stallable.
- wb_rw  in  5  Wr stage destination register.
- wb_data  in  32  Wr stage data.
- lu_valid  in  1  long-unit result valid.
- lu_rw  in  5  long-unit destination register.
- lu_data  in  32  long-unit result.
- lu_ready  out  1  buffer can accept; transfer occurs when lu_valid&lu_ready.
- rf_wen  out  1  to register file wEn.
- rf_rw  out  5  to register file Rw.
- rf_busw  out  32  to register file busW.

Behaviour:
- State:
  - busy[31:0] scoreboard.
  - Result FIFO: LU_FIFO_DEPTH × {rw, data}, with rd/wr pointers and count.
  - outstanding counter, width clog2(MAX_OUTSTANDING+1).
  - starve counter, width clog2(STARVE_LIMIT+1).
- Reset (rst==0 at posedge): busy=0, FIFO empty, outstanding=0, starve=0.
- Outputs while rst==0: rf_wen=0, lu_ready=0, id_stall=1.
- Write-port arbitration (combinational):
  - wb_wen=1: rf_wen=1, rf_rw=wb_rw, rf_busw=wb_data. FIFO does not pop.
  - Otherwise, FIFO non-empty: pop head. rf_rw=head.rw, rf_busw=head.data, rf_wen=(head.rw!=0).
  - Otherwise: rf_wen=0, rf_rw=0, rf_busw=0.
- lu_ready = (count < LU_FIFO_DEPTH). Push on lu_valid&lu_ready.
  - Simultaneous push and pop while full is not allowed: ready is based on registered count only.
  - Push and pop in the same cycle while non-full leaves count unchanged.
- Pop (pipeline drain): clear busy[head.rw] and decrement outstanding.
- Issue: iss = id_valid & id_long & id_wen & !id_stall.
  - On iss: set busy[id_rw] if id_rw!=0, and increment outstanding.
  - A same-cycle pop and iss leave outstanding unchanged.
  - Set and clear of the same register cannot coincide: a WAW stall blocks the set.
- id_stall = id_valid & any of:
  - busy[id_ra] for id_ra!=0;
  - busy[id_rb] for id_rb!=0;
  - id_wen & busy[id_rw] for id_rw!=0 (WAW);
  - id_long & (outstanding==MAX_OUTSTANDING);
  - starve==STARVE_LIMIT.
  - Uses registered busy only: no same-cycle clear bypass, so one extra stall cycle after writeback is accepted.
- Starvation counter:
  - Increments when FIFO is non-empty and wb_wen=1; saturates at STARVE_LIMIT.
  - Clears on any pop or when FIFO is empty.
- Register 0: never marked busy and never written, but its entries still pop and decrement outstanding.
- Reset mid-operation discards buffered results and scoreboard state. Upstream must flush the long unit in the same reset.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - A wb_entry_t struct {rw, data}.
- One natural sub-module: rf_wb_fifo, a synchronous FIFO with push/pop/count/head, sync active-low rst.
- Scoreboard, arbitration and starvation logic stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles with lu_valid=1 -> rf_wen=0, lu_ready=0, id_stall=1. After release: busy=0, lu_ready=1.
- Long issue plus RAW: issue long op rw=5, then id_ra=5 -> id_stall=1 until lu result {5, 0xDEADBEEF} pops with wb_wen=0. Then rf_wen=1, rf_rw=5, rf_busw=0xDEADBEEF, and stall drops the following cycle.
- Conflict: lu result {7, 0x11} arrives while wb_wen=1 with {3, 0x22} -> port writes r3=0x22. r7=0x11 is written the first cycle wb_wen=0.
- Starvation: FIFO holds one entry with wb_wen=1 continuously -> id_stall rises after 4 cycles. Once wb_wen drops, the entry pops and stall clears.
- Full/limits:
  - Issue 4 long ops (rw=1..4); 5th long op -> stall.
  - Fill FIFO with 2 results under wb_wen=1 -> lu_ready=0. One pop -> lu_ready=1.
- r0 and WAW:
  - Long op rw=0 -> busy unchanged; its pop gives rf_wen=0 and outstanding decrements.
  - Op with id_wen=1, rw=9 while busy[9] -> id_stall=1.
